// File: rtl/serial_cmd_parser.sv
// -----------------------------------------------------------------------------
// serial_cmd_parser
//
// Packet-level controller between the UART receiver and the register file.
// Frames the received byte stream into write-command packets of the form
//   SYNC_BYTE, ADDR, LEN, LEN payload bytes, CSUM
// where CSUM == ADDR ^ LEN ^ payload[0] ^ ... ^ payload[LEN-1].
// A packet with a good length and checksum is buffered, then replayed as a
// valid/ready register-write burst to consecutive addresses (8-bit wrap).
//
// Optional feature macro: CMD_PARSER_TIMEOUT_EN
//   Defined     : an inter-byte timeout of TIMEOUT_CLKS cycles aborts a partial
//                 packet in the ADDR/LEN/DATA/CSUM states and pulses timeout_err.
//   Not defined : no timeout counter; timeout_err is tied low and a stalled
//                 partial packet waits indefinitely.
//
// Parameters
//   MAX_LEN       max payload bytes per packet, sizes the buffer (1..255)
//   TIMEOUT_CLKS  inter-byte timeout in clk cycles (timeout build only)
//   SYNC_BYTE     packet start marker
//
// Ports
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   rx_data      in   received byte, valid while rx_new_data=1
//   rx_new_data  in   one-cycle strobe per received byte
//   wr_valid     out  write request valid
//   wr_ready     in   sink accepts the write when wr_valid & wr_ready
//   wr_addr      out  write address
//   wr_data      out  write data
//   busy         out  high in every state except S_SYNC
//   pkt_ok       out  pulse when the last write of a packet is accepted
//   csum_err     out  pulse on checksum mismatch
//   len_err      out  pulse on LEN==0 or LEN>MAX_LEN
//   overrun      out  pulse when a byte arrives while draining (byte dropped)
//   timeout_err  out  pulse on inter-byte timeout
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_cmd_parser #(
    parameter int          MAX_LEN      = 16,
    parameter int          TIMEOUT_CLKS = 500000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_new_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       pkt_ok,
    output logic       csum_err,
    output logic       len_err,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_SYNC,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         csum_q, csum_d;
    // Payload length is held as LEN-1 so it fits the buffer index width.
    logic [IDX_W-1:0]   lenm1_q, lenm1_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_next;

    logic               wr_valid_q, wr_valid_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               pkt_ok_q, pkt_ok_d;
    logic               csum_err_q, csum_err_d;
    logic               len_err_q, len_err_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;

    logic [7:0]         pay_q [MAX_LEN];
    logic               pay_we;

    logic               tmo_hit;

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Fires on the TIMEOUT_CLKS-th consecutive idle cycle of a partial packet.
    always_comb begin
        tmo_hit = 1'b0;
        if ((state_q == S_ADDR || state_q == S_LEN ||
             state_q == S_DATA || state_q == S_CSUM) &&
            !rx_new_data && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1))) begin
            tmo_hit = 1'b1;
        end
    end

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (rx_new_data || state_q == S_SYNC || state_q == S_DRAIN ||
            state_d == S_SYNC) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign idx_next = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        csum_d     = csum_q;
        lenm1_d    = lenm1_q;
        idx_d      = idx_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pkt_ok_d   = 1'b0;
        csum_err_d = 1'b0;
        len_err_d  = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;
        pay_we     = 1'b0;

        unique case (state_q)
            S_SYNC: begin
                if (rx_new_data && rx_data == SYNC_BYTE) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_new_data) begin
                    addr_d  = rx_data;
                    csum_d  = rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_new_data) begin
                    csum_d = csum_q ^ rx_data;
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        len_err_d = 1'b1;
                        state_d   = S_SYNC;
                    end else begin
                        lenm1_d = IDX_W'(rx_data - 8'd1);
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_new_data) begin
                    pay_we = 1'b1;
                    csum_d = csum_q ^ rx_data;
                    idx_d  = idx_next;
                    if (idx_q == lenm1_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_new_data) begin
                    if (rx_data == csum_q) begin
                        // Present the first write right away so wr_valid rises
                        // in the cycle after the CSUM strobe.
                        idx_d      = '0;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = pay_q[0];
                        state_d    = S_DRAIN;
                    end else begin
                        csum_err_d = 1'b1;
                        state_d    = S_SYNC;
                    end
                end
            end
            S_DRAIN: begin
                // Bytes arriving while draining are dropped, including one
                // coinciding with the final accept.
                overrun_d = rx_new_data;
                if (wr_valid_q && wr_ready) begin
                    if (idx_q == lenm1_q) begin
                        wr_valid_d = 1'b0;
                        pkt_ok_d   = 1'b1;
                        state_d    = S_SYNC;
                    end else begin
                        idx_d     = idx_next;
                        wr_addr_d = addr_q + 8'(idx_next);
                        wr_data_d = pay_q[idx_next];
                    end
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = S_SYNC;
        end
    end

    assign busy_d = (state_d != S_SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SYNC;
            addr_q     <= '0;
            csum_q     <= '0;
            lenm1_q    <= '0;
            idx_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            csum_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            csum_q     <= csum_d;
            lenm1_q    <= lenm1_d;
            idx_q      <= idx_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            pkt_ok_q   <= pkt_ok_d;
            csum_err_q <= csum_err_d;
            len_err_q  <= len_err_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    // Payload buffer holds data only; it is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (pay_we) begin
            pay_q[idx_q] <= rx_data;
        end
    end

    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign pkt_ok      = pkt_ok_q;
    assign csum_err    = csum_err_q;
    assign len_err     = len_err_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule
